// File: rtl/alu_rmw_seq.sv
// -----------------------------------------------------------------------------
// alu_rmw_seq
// Read-modify-write sequencer for 6502-style shift/rotate/inc/dec memory ops.
// Reads a byte from memory, runs it once through an external ALU, then writes
// the result back. Optionally writes the original value first (DUMMY_WRITE=1),
// which reproduces the 6502 RMW double-write bus pattern.
//
// Ports
//   clock, reset        single clock; asynchronous active-high reset
//   start, op, addr,    request; op/addr/p_in latched when start is accepted
//   p_in                (start is only looked at while busy=0)
//   busy, done, err     status: busy outside IDLE, one-cycle done/err pulses
//   mem_addr, mem_rd,   byte bus master; an access completes at the rising
//   mem_wr, mem_wdata,  edge where mem_ready is high
//   mem_rdata, mem_ready
//   alu_mode, alu_a,    external ALU operands (alu_mode=4'b0100 is pass-through)
//   alu_b, alu_p
//   alu_ar, alu_af      external ALU result and flags
//   p_out               flags produced by the last completed operation
// -----------------------------------------------------------------------------
module alu_rmw_seq #(
  parameter int AW          = 16,
  parameter bit DUMMY_WRITE = 1'b1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [3:0]    op,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    p_in,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata,
  input  logic          mem_ready,
  output logic [3:0]    alu_mode,
  output logic [7:0]    alu_a,
  output logic [7:0]    alu_b,
  output logic [7:0]    alu_p,
  input  logic [7:0]    alu_ar,
  input  logic [7:0]    alu_af,
  output logic [7:0]    p_out
);

  localparam logic [3:0] MODE_PASS = 4'b0100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_MODIFY,
    S_DUMMY,
    S_WRITE,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [3:0]    op_q;
  logic [AW-1:0] addr_q;
  logic [7:0]    p_q;       // flags latched at accept
  logic [7:0]    d_q;       // byte read from memory (also drives alu_b)
  logic [7:0]    r_q;       // ALU result
  logic [7:0]    f_q;       // ALU flags
  logic [7:0]    alu_p_q;   // flags shown to the ALU; held between operations
  logic [7:0]    p_out_q;
  logic          err_q;

  function automatic logic op_legal(input logic [3:0] m);
    case (m)
      4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1101, 4'b1110: op_legal = 1'b1;
      default:                                               op_legal = 1'b0;
    endcase
  endfunction

  logic accept;
  assign accept = (state == S_IDLE) && start && op_legal(op);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Next state and outputs (all decoded from registered state and latched data)
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_wdata = 8'h00;
    alu_mode  = MODE_PASS;

    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (accept) state_nxt = S_READ;
      end
      S_READ: begin
        mem_rd = 1'b1;
        if (mem_ready) state_nxt = S_MODIFY;
      end
      S_MODIFY: begin
        alu_mode  = op_q;
        state_nxt = DUMMY_WRITE ? S_DUMMY : S_WRITE;
      end
      S_DUMMY: begin
        mem_wr    = 1'b1;
        mem_wdata = d_q;
        if (mem_ready) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        mem_wr    = 1'b1;
        mem_wdata = r_q;
        if (mem_ready) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Address is held in a register for the whole transaction, so it cannot move
  // during wait states.
  assign mem_addr = addr_q;
  assign alu_a    = 8'h00;
  assign alu_b    = d_q;
  assign alu_p    = alu_p_q;
  assign p_out    = p_out_q;
  assign err      = err_q;

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: these registers are all reset because their values are visible on
  // outputs straight out of reset; nothing here is a bulk memory.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q    <= 4'h0;
      addr_q  <= '0;
      p_q     <= 8'h00;
      d_q     <= 8'h00;
      r_q     <= 8'h00;
      f_q     <= 8'h00;
      alu_p_q <= 8'h00;
      p_out_q <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      // Illegal requests are rejected with a single-cycle pulse per sample.
      err_q <= (state == S_IDLE) && start && !op_legal(op);

      if (accept) begin
        op_q   <= op;
        addr_q <= addr;
        p_q    <= p_in;
      end

      // Operands for the ALU are captured on entry to MODIFY and then held.
      if (state == S_READ && mem_ready) begin
        d_q     <= mem_rdata;
        alu_p_q <= p_q;
      end

      if (state == S_MODIFY) begin
        r_q <= alu_ar;
        f_q <= alu_af;
      end

      // Flags become architecturally visible only when the final write lands.
      if (state == S_WRITE && mem_ready) p_out_q <= f_q;
    end
  end

endmodule

// File: tb/tb_alu_rmw_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_rmw_seq
// Two instances: index 1 with DUMMY_WRITE=1, index 0 with DUMMY_WRITE=0.
// The external ALU is modelled by a behavioural function computed from the
// 6502 rules (N=bit7, Z=bit1, C=bit0). Bus wait states are injected per access.
// -----------------------------------------------------------------------------
module tb_alu_rmw_seq;

  logic clock = 1'b0;
  logic reset = 1'b1;

  logic [1:0] start     = '0;
  logic [1:0] mem_ready = '0;
  logic [1:0] busy, done, err, mem_rd, mem_wr;
  logic [3:0]  op_v   [2];
  logic [15:0] addr_v [2];
  logic [7:0]  p_v    [2];
  logic [7:0]  rdata_v[2];
  logic [15:0] mem_addr [2];
  logic [7:0]  mem_wdata[2];
  logic [3:0]  alu_mode [2];
  logic [7:0]  alu_a[2], alu_b[2], alu_p[2], alu_ar[2], alu_af[2], p_out[2];

  int n_run  = 0;
  int n_fail = 0;
  logic [7:0] p_model [2];   // expected p_out per instance

  always #5 clock = ~clock;

  // Behavioural 6502 read-modify-write ALU: returns {result, flags}.
  function automatic logic [15:0] ref_alu(input logic [3:0] m, input logic [7:0] b,
                                          input logic [7:0] p);
    int   v;
    logic c;
    logic [7:0] r, f;
    c = p[0];
    v = int'(b);
    case (m)
      4'b1000: begin v = v * 2;                    c = (v >= 256);   end
      4'b1001: begin v = v * 2 + int'(p[0]);       c = (v >= 256);   end
      4'b1010: begin c = (v % 2) == 1; v = v / 2;                    end
      4'b1011: begin c = (v % 2) == 1; v = v / 2 + (p[0] ? 128 : 0); end
      4'b1101: v = (v + 255) % 256;
      4'b1110: v = (v + 1) % 256;
      default: return {b, p};
    endcase
    r    = 8'(v % 256);
    f    = p;
    f[7] = r[7];
    f[1] = (r == 8'h00);
    f[0] = c;
    return {r, f};
  endfunction

  assign {alu_ar[0], alu_af[0]} = ref_alu(alu_mode[0], alu_b[0], alu_p[0]);
  assign {alu_ar[1], alu_af[1]} = ref_alu(alu_mode[1], alu_b[1], alu_p[1]);

  alu_rmw_seq #(.AW(16), .DUMMY_WRITE(1'b0)) u_dw0 (
    .clock(clock), .reset(reset), .start(start[0]), .op(op_v[0]), .addr(addr_v[0]),
    .p_in(p_v[0]), .busy(busy[0]), .done(done[0]), .err(err[0]),
    .mem_addr(mem_addr[0]), .mem_rd(mem_rd[0]), .mem_wr(mem_wr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(rdata_v[0]), .mem_ready(mem_ready[0]),
    .alu_mode(alu_mode[0]), .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_p(alu_p[0]),
    .alu_ar(alu_ar[0]), .alu_af(alu_af[0]), .p_out(p_out[0])
  );

  alu_rmw_seq #(.AW(16), .DUMMY_WRITE(1'b1)) u_dw1 (
    .clock(clock), .reset(reset), .start(start[1]), .op(op_v[1]), .addr(addr_v[1]),
    .p_in(p_v[1]), .busy(busy[1]), .done(done[1]), .err(err[1]),
    .mem_addr(mem_addr[1]), .mem_rd(mem_rd[1]), .mem_wr(mem_wr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(rdata_v[1]), .mem_ready(mem_ready[1]),
    .alu_mode(alu_mode[1]), .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_p(alu_p[1]),
    .alu_ar(alu_ar[1]), .alu_af(alu_af[1]), .p_out(p_out[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_values(input int i, input string tag);
    chk({tag, " busy"},      32'(busy[i]),      32'h0);
    chk({tag, " done"},      32'(done[i]),      32'h0);
    chk({tag, " err"},       32'(err[i]),       32'h0);
    chk({tag, " rd/wr"},     32'({mem_rd[i], mem_wr[i]}), 32'h0);
    chk({tag, " mem_addr"},  32'(mem_addr[i]),  32'h0);
    chk({tag, " mem_wdata"}, 32'(mem_wdata[i]), 32'h0);
    chk({tag, " p_out"},     32'(p_out[i]),     32'h0);
    chk({tag, " alu_mode"},  32'(alu_mode[i]),  32'h4);
    chk({tag, " alu_abp"},   32'({alu_a[i], alu_b[i], alu_p[i]}), 32'h0);
  endtask

  // One complete RMW operation on instance i with rw/dw/ww wait cycles on the
  // read, dummy write and result write. Checks bus pattern, ALU operands,
  // latency and flags. hold keeps start high through the DONE cycle.
  task automatic run_op(input int i, input logic [3:0] o, input logic [15:0] a,
                        input logic [7:0] d, input logic [7:0] p,
                        input logic [7:0] er, input logic [7:0] ef,
                        input int rw, input int dw, input int ww,
                        input bit hold, input bit rel_rst, input string tag);
    int cyc, waits, widx, nw, lim, done_cyc, exp_done;
    logic [7:0] exp_w [2];
    nw       = (i == 1) ? 2 : 1;
    exp_w[0] = (i == 1) ? d : er;
    exp_w[1] = er;
    exp_done = (i == 1) ? 5 + rw + dw + ww : 4 + rw + ww;

    @(negedge clock);
    if (rel_rst) reset = 1'b0;
    start[i] = 1'b1; op_v[i] = o; addr_v[i] = a; p_v[i] = p;
    @(negedge clock);
    if (!hold) start[i] = 1'b0;
    cyc = 1; waits = 0; widx = 0; done_cyc = 0;

    while (cyc < 60 && done_cyc == 0) begin
      mem_ready[i] = 1'b0;
      rdata_v[i]   = ~d;           // garbage unless this is the completing cycle
      chk({tag, " rd&wr exclusive"}, 32'(mem_rd[i] & mem_wr[i]), 32'h0);
      if (mem_rd[i]) begin
        chk({tag, " rd addr"}, 32'(mem_addr[i]), 32'(a));
        chk({tag, " rd alu_mode"}, 32'(alu_mode[i]), 32'h4);
        if (waits == rw) begin
          rdata_v[i] = d; mem_ready[i] = 1'b1; waits = 0;
        end else waits++;
      end else if (mem_wr[i]) begin
        chk({tag, " wr addr"}, 32'(mem_addr[i]), 32'(a));
        chk({tag, " wr alu_mode"}, 32'(alu_mode[i]), 32'h4);
        if (widx < nw) begin
          chk({tag, " wr data"}, 32'(mem_wdata[i]), 32'(exp_w[widx]));
          lim = (widx == nw - 1) ? ww : dw;
          if (waits == lim) begin
            mem_ready[i] = 1'b1; waits = 0; widx++;
          end else waits++;
        end else begin
          chk({tag, " extra write"}, 32'(widx), 32'(nw - 1));
          mem_ready[i] = 1'b1;
        end
      end else if (done[i]) begin
        done_cyc   = cyc;
        p_model[i] = ef;
      end else if (busy[i]) begin
        chk({tag, " modify alu_mode"}, 32'(alu_mode[i]), 32'(o));
        chk({tag, " modify alu_abp"}, 32'({alu_a[i], alu_b[i], alu_p[i]}),
            32'({8'h00, d, p}));
      end
      chk({tag, " p_out"}, 32'(p_out[i]), 32'(p_model[i]));
      if (done_cyc == 0) begin
        @(negedge clock);
        cyc++;
      end
    end
    mem_ready[i] = 1'b0;
    chk({tag, " done cycle"}, 32'(done_cyc), 32'(exp_done));
    chk({tag, " write count"}, 32'(widx), 32'(nw));

    @(negedge clock);
    chk({tag, " idle busy"}, 32'({busy[i], done[i]}), 32'h0);
    chk({tag, " idle p_out"}, 32'(p_out[i]), 32'(ef));
    start[i] = 1'b0;
    @(negedge clock);
    chk({tag, " start ignored"}, 32'({busy[i], mem_rd[i], mem_wr[i]}), 32'h0);
  endtask

  task automatic illegal_op(input int i, input logic [3:0] o, input string tag);
    @(negedge clock);
    start[i] = 1'b1; op_v[i] = o; addr_v[i] = 16'h1234;
    @(negedge clock);
    chk({tag, " err"},   32'(err[i]), 32'h1);
    chk({tag, " busy"},  32'({busy[i], mem_rd[i], mem_wr[i]}), 32'h0);
    start[i] = 1'b0;
    @(negedge clock);
    chk({tag, " err pulse"}, 32'(err[i]), 32'h0);
    chk({tag, " still idle"}, 32'({busy[i], mem_rd[i], mem_wr[i]}), 32'h0);
    chk({tag, " p_out"}, 32'(p_out[i]), 32'(p_model[i]));
  endtask

  logic [3:0] legal_ops [6];

  initial begin
    logic [15:0] rf;
    int          i, rw, dw, ww;
    logic [3:0]  o;
    logic [7:0]  d, p;

    legal_ops[0] = 4'b1000; legal_ops[1] = 4'b1001; legal_ops[2] = 4'b1010;
    legal_ops[3] = 4'b1011; legal_ops[4] = 4'b1101; legal_ops[5] = 4'b1110;
    for (int k = 0; k < 2; k++) begin
      op_v[k] = 4'h0; addr_v[k] = 16'h0; p_v[k] = 8'h0; rdata_v[k] = 8'h0;
      p_model[k] = 8'h00;
    end

    #2;
    chk_reset_values(1, "reset dw1");
    chk_reset_values(0, "reset dw0");
    repeat (2) @(negedge clock);

    // ASL 0x81 -> writes 0x81 then 0x02, p_out 0x01; start on first edge after reset.
    run_op(1, 4'b1000, 16'h0200, 8'h81, 8'h00, 8'h02, 8'h01, 0, 0, 0, 1'b0, 1'b1, "asl");
    // INC 0xFF, p 0x80 -> 0xFF then 0x00, p_out 0x02.
    run_op(1, 4'b1110, 16'h0300, 8'hFF, 8'h80, 8'h00, 8'h02, 0, 0, 0, 1'b1, 1'b0, "inc");
    // ROR 0x01, p 0x01, 3 read waits + 2 write waits -> done cycle 10, p_out 0x81.
    run_op(1, 4'b1011, 16'h0400, 8'h01, 8'h01, 8'h80, 8'h81, 3, 0, 2, 1'b0, 1'b0, "ror");
    // DUMMY_WRITE=0: DEC 0x01 -> single write 0x00, done cycle 4, Z=1.
    run_op(0, 4'b1101, 16'h0500, 8'h01, 8'h00, 8'h00, 8'h02, 0, 0, 0, 1'b0, 1'b0, "dec dw0");

    illegal_op(1, 4'b0011, "illegal 0011");
    illegal_op(0, 4'b1111, "illegal 1111");

    // Reset while in DUMMY: strobe drops immediately, operation is abandoned.
    @(negedge clock);
    start[1] = 1'b1; op_v[1] = 4'b1000; addr_v[1] = 16'h0600; p_v[1] = 8'h00;
    @(negedge clock);                           // cycle 1: READ
    start[1] = 1'b0;
    rdata_v[1] = 8'h40; mem_ready[1] = 1'b1;
    @(negedge clock);                           // cycle 2: MODIFY
    mem_ready[1] = 1'b0;
    @(negedge clock);                           // cycle 3: DUMMY
    chk("rst dummy wr before", 32'(mem_wr[1]), 32'h1);
    reset = 1'b1;
    #1;
    p_model[0] = 8'h00; p_model[1] = 8'h00;
    chk_reset_values(1, "rst dummy");
    mem_ready[1] = 1'b1;                        // a ready bus must not revive it
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      chk("rst no strobe", 32'({busy[1], mem_rd[1], mem_wr[1], done[1]}), 32'h0);
      chk("rst p_out", 32'(p_out[1]), 32'h0);
    end
    mem_ready[1] = 1'b0;

    // Randomized operations against the behavioural ALU model.
    for (int k = 0; k < 24; k++) begin
      i  = int'($urandom_range(0, 1));
      o  = legal_ops[$urandom_range(0, 5)];
      d  = 8'($urandom);
      p  = 8'($urandom);
      rw = int'($urandom_range(0, 2));
      dw = int'($urandom_range(0, 2));
      ww = int'($urandom_range(0, 2));
      rf = ref_alu(o, d, p);
      run_op(i, o, 16'($urandom), d, p, rf[15:8], rf[7:0], rw, dw, ww,
             1'($urandom_range(0, 1)), 1'b0, $sformatf("rand%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
